// File: rtl/ex6_out_trace_pkg.sv
// rtl/ex6_out_trace_pkg.sv - shared types and widths for the ex6 output trace capture
package ex6_trace_pkg;

  localparam int Y_W      = 8;
  localparam int TS_W_DEF = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2
  } state_t;

  // Layout of one out_data word at the default timestamp width
  typedef struct packed {
    logic [TS_W_DEF-1:0] ts;
    logic [Y_W-1:0]      y;
  } entry_t;

endpackage

// File: rtl/ex6_out_trace_if.sv
// rtl/ex6_out_trace_if.sv - valid/ready trace entry port
interface ex6_out_trace_if #(
  parameter int TS_W = 12
);
  import ex6_trace_pkg::*;

  logic                out_valid;
  logic                out_ready;
  logic [TS_W+Y_W-1:0] out_data;

  modport master (output out_valid, output out_data, input out_ready);
  modport slave  (input out_valid, input out_data, output out_ready);

endinterface

// File: rtl/ex6_out_trace_fifo.sv
// rtl/ex6_out_trace_fifo.sv - synchronous show-ahead FIFO; a push while full lands only if a pop frees the slot
module trace_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 20
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [W-1:0]               wr_data,
  input  logic                       rd_en,
  output logic [W-1:0]               rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = rd_en && !empty;
  assign do_push = wr_en && (!full || do_pop);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ex6_out_trace.sv
// rtl/ex6_out_trace.sv - capture y1..y8 changes as timestamped entries after a programmable trigger
module ex6_out_trace
  import ex6_trace_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int TS_W      = 12,
  parameter int STUCK_LIM = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [Y_W-1:0]         y_in,
  input  logic                   en,
  input  logic [Y_W-1:0]         trig_mask,
  input  logic [Y_W-1:0]         trig_val,
  ex6_out_trace_if.master        out,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  input  logic                   clr_ovf,
  output logic [7:0]             drop_cnt,
  output logic                   stuck
);
  state_t         state;
  state_t         state_nx;
  logic [TS_W-1:0] ts;
  logic [Y_W-1:0] prev_y;
  logic [15:0]    still_cnt;
  logic           change;
  logic           trig_hit;
  logic           push;
  logic           pop;
  logic           drop;
  logic           full;
  logic           empty;

  assign change   = (y_in != prev_y);
  assign trig_hit = (((y_in ^ trig_val) & trig_mask) == '0);
  assign pop      = out.out_valid && out.out_ready;
  assign drop     = push && full && !pop;
  assign stuck    = (still_cnt >= 16'(STUCK_LIM));
  assign out.out_valid = !empty;

  always_comb begin
    state_nx = state;
    push     = 1'b0;
    case (state)
      IDLE:  if (en) state_nx = ARMED;
      ARMED: begin
        if (!en) begin
          state_nx = IDLE;
        end else if (trig_hit) begin
          state_nx = RUN;
          push     = 1'b1;
        end
      end
      RUN: begin
        if (!en) state_nx = IDLE;
        else     push = change;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ts        <= '0;
      prev_y    <= '0;
      still_cnt <= '0;
      overflow  <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      state  <= state_nx;
      ts     <= ts + 1'b1;
      prev_y <= y_in;
      if (change)                    still_cnt <= '0;
      else if (still_cnt != 16'hFFFF) still_cnt <= still_cnt + 1'b1;
      // A drop in the same cycle as clr_ovf wins and starts the count afresh
      if (drop) begin
        overflow <= 1'b1;
        if (clr_ovf)                 drop_cnt <= 8'd1;
        else if (drop_cnt != 8'hFF)  drop_cnt <= drop_cnt + 1'b1;
      end else if (clr_ovf) begin
        overflow <= 1'b0;
        drop_cnt <= '0;
      end
    end
  end

  trace_fifo #(
    .DEPTH (DEPTH),
    .W     (TS_W + Y_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push),
    .wr_data ({ts, y_in}),
    .rd_en   (out.out_ready),
    .rd_data (out.out_data),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

endmodule

// File: tb/tb_ex6_out_trace.sv
// tb/tb_ex6_out_trace.sv - directed stimulus with a queue-based reference model and literal spot checks
module tb_ex6_out_trace;
  import ex6_trace_pkg::*;

  localparam int DEPTH     = 16;
  localparam int TS_W      = 12;
  localparam int STUCK_LIM = 64;
  localparam int DW        = TS_W + Y_W;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       clr_ovf;
  logic [7:0] y_in;
  logic [7:0] trig_mask;
  logic [7:0] trig_val;
  logic [4:0] count;
  logic       overflow;
  logic       stuck;
  logic [7:0] drop_cnt;

  int checks   = 0;
  int failures = 0;

  ex6_out_trace_if #(.TS_W(TS_W)) tif ();

  ex6_out_trace #(
    .DEPTH     (DEPTH),
    .TS_W      (TS_W),
    .STUCK_LIM (STUCK_LIM)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .y_in      (y_in),
    .en        (en),
    .trig_mask (trig_mask),
    .trig_val  (trig_val),
    .out       (tif),
    .count     (count),
    .overflow  (overflow),
    .clr_ovf   (clr_ovf),
    .drop_cnt  (drop_cnt),
    .stuck     (stuck)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Reference model: entries as a queue, occupancy is just its size
  logic [DW-1:0] mq[$];
  logic [DW-1:0] log_q[$];
  int            m_mode;
  int            m_ts;
  logic [7:0]    m_prev;
  bit            m_ovf;
  int            m_drops;
  int            m_still;
  bit            model_ok = 1'b0;

  always @(posedge clk) begin : model
    bit            do_push;
    bit            chg;
    logic [DW-1:0] ent;
    if (rst) begin
      mq.delete();
      m_mode = 0; m_ts = 0; m_prev = 8'h00; m_ovf = 1'b0; m_drops = 0; m_still = 0;
      model_ok = 1'b1;
    end else if (model_ok) begin
      chg     = (y_in != m_prev);
      ent     = {m_ts[TS_W-1:0], y_in};
      do_push = 1'b0;
      if (m_mode == 0) begin
        if (en) m_mode = 1;
      end else if (!en) begin
        m_mode = 0;
      end else if (m_mode == 1) begin
        if (((y_in ^ trig_val) & trig_mask) == 8'h00) begin
          m_mode  = 2;
          do_push = 1'b1;
        end
      end else begin
        do_push = chg;
      end
      if (mq.size() > 0 && tif.out_ready) void'(mq.pop_front());
      if (do_push && mq.size() < DEPTH) begin
        mq.push_back(ent);
        if (clr_ovf) begin m_ovf = 1'b0; m_drops = 0; end
      end else if (do_push) begin
        m_ovf   = 1'b1;
        m_drops = clr_ovf ? 1 : (m_drops < 255 ? m_drops + 1 : 255);
      end else if (clr_ovf) begin
        m_ovf = 1'b0; m_drops = 0;
      end
      m_still = chg ? 0 : (m_still < 65535 ? m_still + 1 : 65535);
      m_prev  = y_in;
      m_ts    = (m_ts + 1) % (1 << TS_W);
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      chk("out_valid", 32'(tif.out_valid), 32'(mq.size() > 0));
      if (mq.size() > 0) chk("out_data", 32'(tif.out_data), 32'(mq[0]));
      chk("count", 32'(count), 32'(mq.size()));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("drop_cnt", 32'(drop_cnt), 32'(m_drops));
      chk("stuck", 32'(stuck), 32'(m_still >= STUCK_LIM));
      if (tif.out_valid && tif.out_ready) log_q.push_back(tif.out_data);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; clr_ovf = 1'b0;
    step();
    rst = 1'b0;
    log_q.delete();
  endtask

  logic [DW-1:0] e;

  initial begin
    rst = 1'b1; en = 1'b0; clr_ovf = 1'b0; y_in = 8'h00;
    trig_mask = 8'h00; trig_val = 8'h00; tif.out_ready = 1'b1;

    // Trigger on first enabled cycle at ts=5, then capture changes only
    do_reset();
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_valid", 32'(tif.out_valid), 32'd0);
    repeat (4) step();
    en = 1'b1; step();
    step();
    y_in = 8'h1D; step(); step();
    y_in = 8'h14; step();
    repeat (3) step();
    chk("t1_n", 32'(log_q.size()), 32'd3);
    e = log_q[0]; chk("t1_e0", 32'(e), 32'({12'd5, 8'h00}));
    e = log_q[1]; chk("t1_e1", 32'(e), 32'({12'd6, 8'h1D}));
    e = log_q[2]; chk("t1_e2", 32'(e), 32'({12'd8, 8'h14}));

    // Masked trigger: toggles before the match produce nothing
    do_reset();
    trig_mask = 8'hFF; trig_val = 8'h03; en = 1'b1; y_in = 8'h1D;
    step();
    for (int i = 0; i < 10; i++) begin
      y_in = (i % 2) ? 8'h1D : 8'h14;
      step();
    end
    chk("t2_pre", 32'(log_q.size()), 32'd0);
    y_in = 8'h03; step();
    y_in = 8'h05; step();
    y_in = 8'h06; step();
    repeat (3) step();
    chk("t2_n", 32'(log_q.size()), 32'd3);
    e = log_q[0]; chk("t2_first", 32'(e[7:0]), 32'h03);
    e = log_q[2]; chk("t2_last", 32'(e[7:0]), 32'h06);

    // Overflow: 20 changes into 16 slots with the consumer stalled
    do_reset();
    trig_mask = 8'h00; en = 1'b1; y_in = 8'h00; tif.out_ready = 1'b1;
    step(); step(); step(); step();
    tif.out_ready = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      y_in = 8'(i);
      step();
    end
    chk("t3_count", 32'(count), 32'd16);
    chk("t3_ovf", 32'(overflow), 32'd1);
    chk("t3_drops", 32'(drop_cnt), 32'd4);
    e = tif.out_data; chk("t3_head", 32'(e[7:0]), 32'h01);
    clr_ovf = 1'b1; step(); clr_ovf = 1'b0;
    chk("t3_clr_ovf", 32'(overflow), 32'd0);
    chk("t3_clr_drops", 32'(drop_cnt), 32'd0);

    // Full FIFO with push and pop on the same edge
    y_in = 8'h55; tif.out_ready = 1'b1; step();
    tif.out_ready = 1'b0;
    chk("t4_count", 32'(count), 32'd16);
    chk("t4_drops", 32'(drop_cnt), 32'd0);
    e = tif.out_data; chk("t4_head", 32'(e[7:0]), 32'h02);
    log_q.delete();
    tif.out_ready = 1'b1;
    repeat (18) step();
    chk("t4_n", 32'(log_q.size()), 32'd16);
    e = log_q[15]; chk("t4_tail", 32'(e[7:0]), 32'h55);

    // Stuck detection on a constant output
    do_reset();
    y_in = 8'h00;
    repeat (63) step();
    chk("t5_63", 32'(stuck), 32'd0);
    step();
    chk("t5_64", 32'(stuck), 32'd1);
    y_in = 8'h03; step();
    chk("t5_clear", 32'(stuck), 32'd0);

    // Reset mid-RUN empties the FIFO and restarts the timestamp
    do_reset();
    tif.out_ready = 1'b0; en = 1'b1; trig_mask = 8'h00; y_in = 8'h00;
    step(); step();
    for (int i = 1; i <= 4; i++) begin
      y_in = 8'(i);
      step();
    end
    chk("t6_pre", 32'(count), 32'd5);
    rst = 1'b1; y_in = 8'h77; step();
    rst = 1'b0;
    log_q.delete();
    chk("t6_count", 32'(count), 32'd0);
    chk("t6_valid", 32'(tif.out_valid), 32'd0);
    chk("t6_ovf", 32'(overflow), 32'd0);
    tif.out_ready = 1'b1;
    step(); step();
    repeat (3) step();
    chk("t6_n", 32'(log_q.size()), 32'd1);
    e = log_q[0]; chk("t6_entry", 32'(e), 32'({12'd1, 8'h77}));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ex6_out_trace.md
# ex6_out_trace

Downstream capture stage for the ex6 controller: samples the 8-bit output vector y1..y8 every cycle, records each change as a timestamped entry in a small FIFO, and exposes the entries over a valid/ready port. It arms on a programmable trigger pattern, reports overflow and a "stuck output" condition, and exists so benches and on-chip debug can see the controller's output sequence, including key-dependent and counter-dependent divergence.

## Interface
Parameters:
- DEPTH, 16: FIFO entries; power of two, ≥2.
- TS_W, 12: timestamp width.
- STUCK_LIM, 64: unchanged-output cycles before `stuck` asserts; 1..2^16-1.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- y_in  in  8  controller outputs, {y8..y1}; bit 0 = y1.
- en  in  1  capture enable; low forces IDLE.
- trig_mask  in  8  trigger compare mask.
- trig_val  in  8  trigger compare value.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer accepts head.
- out_data  out  TS_W+8  {timestamp, y}; y in the low 8 bits.
- count  out  $clog2(DEPTH)+1  current occupancy.
- overflow  out  1  sticky; an entry was dropped.
- clr_ovf  in  1  clears `overflow` and `drop_cnt`.
- drop_cnt  out  8  dropped entries, saturates at 255.
- stuck  out  1  y_in unchanged for ≥STUCK_LIM cycles.

## Operation
- Reset values: all outputs 0, state IDLE, timestamp 0, prev_y 0, FIFO empty, stuck counter 0.
- Timestamp: free-running TS_W counter, +1 every cycle, wraps to 0. Never gated by `en`.
- prev_y: loaded with y_in every cycle. change = (y_in != prev_y).
- FSM:
  - IDLE: en=1 -> ARMED.
  - ARMED: en=0 -> IDLE. ((y_in ^ trig_val) & trig_mask)==0 -> RUN, and that cycle's sample is pushed unconditionally (trigger entry). mask=0 triggers on the first enabled cycle.
  - RUN: push on change. en=0 -> IDLE, with no push in that cycle.
- FIFO contents survive IDLE; only rst empties it.
- Push when full: if out_valid&&out_ready in the same cycle, the push is accepted and count is unchanged. Otherwise the entry is dropped, overflow=1, and drop_cnt increments with saturation.
- Pop: out_valid&&out_ready. out_data holds the head, stable while valid && !ready.
- Simultaneous push/pop when empty: no bypass. The pushed entry appears the next cycle.
- clr_ovf with a drop in the same cycle: the drop wins, so overflow=1 and drop_cnt=1.
- Stuck: a 16-bit saturating counter. It resets to 0 on change and otherwise increments. stuck = (counter ≥ STUCK_LIM). It runs in every state.

## Timing
- Sample at edge N with a push gives out_valid=1 and out_data={ts_N, y_N} after edge N+1. ts_N is the timestamp value at edge N.
- count, overflow and drop_cnt are registered and update at the same edge as the push/pop.
- stuck asserts at the edge where the counter reaches STUCK_LIM and deasserts at the edge after a change is sampled.
- rst has priority over every other input in the same cycle.

## Structure
- ex6_trace_pkg holds:
  - the state enum (IDLE, ARMED, RUN);
  - Y_W=8;
  - the entry struct {ts, y}.
- Sub-module trace_fifo: a parameterised synchronous FIFO (DEPTH, width) with full/empty/count and a show-ahead head. The top holds the FSM, change detection, timestamp, stuck and drop logic.

## Test plan
- Reset then en=1, mask=0, y_in sequence 0x00,0x1D,0x1D,0x14 starting at ts=5 (out_ready=1) -> entries {5,0x00},{6,0x1D},{8,0x14}.
- mask=0xFF, val=0x03, y_in toggles 0x1D/0x14 for 10 cycles, then 0x03 -> no entries before 0x03; the first entry is y=0x03, and later changes are captured.
- out_ready=0, 20 changes with DEPTH=16 -> count=16, overflow=1, drop_cnt=4, head = first change. Then clr_ovf -> overflow=0, drop_cnt=0.
- Full FIFO with pop and push in the same cycle -> count stays 16, no drop, new entry at tail.
- y_in held at 0x00 for 64 cycles -> stuck=1 at the 64th edge; a change to 0x03 -> stuck=0 the next cycle.
- rst asserted mid-RUN with 5 entries queued -> next cycle count=0, out_valid=0, overflow=0, state IDLE, timestamp=0.
